// File: rtl/sram_arbiter_if.sv
// Bundles the two requester handshakes and the external SRAM pins for the arbiter.
// No logic: pure signal grouping, so no latency of its own.
// Backpressure is the level req held until the ack/vld pulse.
interface sram_arbiter_if;
    // write requester
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    // read requester
    logic        rd_req;
    logic [17:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_vld;
    // status
    logic        busy;
    // SRAM side
    logic [18:0] sram_addr;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic [15:0] data_o;
    logic        data_oe;
    logic [15:0] data_i;

    // arbiter side
    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, data_i,
        output wr_ack, rd_data, rd_vld, busy,
        output sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        output data_o, data_oe
    );

    // requesters plus pad/SRAM side
    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, data_i,
        input  wr_ack, rd_data, rd_vld, busy,
        input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        input  data_o, data_oe
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter splitting 32-bit write/read requests into two 16-bit async SRAM accesses.
// Latency: grant edge to ack/vld pulse = 2*ACC_CYC edges; the requester samples it on the next edge.
// Backpressure: requests are levels; a request raised while busy simply waits in IDLE arbitration.
module sram_arbiter #(
    parameter int unsigned ACC_CYC = 2
) (
    input  logic          clk,
    input  logic          clr,
    sram_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_LO = 3'd1,
        WR_HI = 3'd2,
        RD_LO = 3'd3,
        RD_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(ACC_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_wr_q, last_wr_d;     // 1: last grant (and current op) was the write side
    logic [17:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [15:0] rd_lo_q, rd_lo_d;         // shadow of the even word until the pair is complete
    logic [31:0] rd_data_q, rd_data_d;

    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        bs_n_q, bs_n_d;           // ub_n and lb_n always move together
    logic [18:0] sram_addr_q, sram_addr_d;
    logic [15:0] data_o_q, data_o_d;
    logic        data_oe_q, data_oe_d;
    logic        wr_ack_q, wr_ack_d;
    logic        rd_vld_q, rd_vld_d;
    logic        busy_q, busy_d;

    logic        phase_end;

    assign phase_end = (cnt_q == CNT_LAST);

    // Next state, phase counter, grant bookkeeping and captured read data.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rd_lo_d   = rd_lo_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                // A tie goes to the side that was not served last.
                if (bus.wr_req && (!bus.rd_req || !last_wr_q)) begin
                    state_d   = WR_LO;
                    last_wr_d = 1'b1;
                    addr_d    = bus.wr_addr;
                    wdat_d    = bus.wr_data;
                end else if (bus.rd_req) begin
                    state_d   = RD_LO;
                    last_wr_d = 1'b0;
                    addr_d    = bus.rd_addr;
                end
            end
            WR_LO, WR_HI, RD_LO, RD_HI: begin
                if (phase_end) begin
                    cnt_d = 4'd0;
                    case (state_q)
                        WR_LO:   state_d = WR_HI;
                        RD_LO: begin
                            state_d = RD_HI;
                            rd_lo_d = bus.data_i;
                        end
                        RD_HI: begin
                            state_d   = DONE;
                            // Both halves land together so a half-updated word is never visible.
                            rd_data_d = {bus.data_i, rd_lo_q};
                        end
                        default: state_d = DONE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values for the state/phase being entered, so every pin is a flop output.
    always_comb begin
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        bs_n_d      = 1'b1;
        data_oe_d   = 1'b0;
        sram_addr_d = sram_addr_q;
        data_o_d    = data_o_q;
        wr_ack_d    = 1'b0;
        rd_vld_d    = 1'b0;
        busy_d      = (state_d != IDLE);
        case (state_d)
            WR_LO, WR_HI: begin
                ce_n_d      = 1'b0;
                bs_n_d      = 1'b0;
                data_oe_d   = 1'b1;
                // Release we_n one cycle early so address and data are held past the write edge.
                we_n_d      = (cnt_d == CNT_LAST);
                sram_addr_d = {addr_d, (state_d == WR_HI)};
                data_o_d    = (state_d == WR_HI) ? wdat_d[31:16] : wdat_d[15:0];
            end
            RD_LO, RD_HI: begin
                ce_n_d      = 1'b0;
                oe_n_d      = 1'b0;
                bs_n_d      = 1'b0;
                sram_addr_d = {addr_d, (state_d == RD_HI)};
            end
            DONE: begin
                wr_ack_d = last_wr_d;
                rd_vld_d = !last_wr_d;
            end
            default: ;
        endcase
    end

    // State and registered outputs; clr aborts any access in flight without an ack.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_wr_q   <= 1'b0;
            addr_q      <= 18'd0;
            wdat_q      <= 32'd0;
            rd_lo_q     <= 16'd0;
            rd_data_q   <= 32'd0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            bs_n_q      <= 1'b1;
            sram_addr_q <= 19'd0;
            data_o_q    <= 16'd0;
            data_oe_q   <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_vld_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_wr_q   <= last_wr_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            rd_lo_q     <= rd_lo_d;
            rd_data_q   <= rd_data_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            bs_n_q      <= bs_n_d;
            sram_addr_q <= sram_addr_d;
            data_o_q    <= data_o_d;
            data_oe_q   <= data_oe_d;
            wr_ack_q    <= wr_ack_d;
            rd_vld_q    <= rd_vld_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.wr_ack    = wr_ack_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_vld    = rd_vld_q;
    assign bus.busy      = busy_q;
    assign bus.sram_addr = sram_addr_q;
    assign bus.sram_ce_n = ce_n_q;
    assign bus.sram_oe_n = oe_n_q;
    assign bus.sram_we_n = we_n_q;
    assign bus.sram_ub_n = bs_n_q;
    assign bus.sram_lb_n = bs_n_q;
    assign bus.data_o    = data_o_q;
    assign bus.data_oe   = data_oe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vector table, abort/latch corner cases, randomized arbitration.
// Two instances: ACC_CYC=2 for most tests, ACC_CYC=4 for the input-latching case.
// Each instance has a 16-bit SRAM model that logs every completed write pulse.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic clr;
    always #50 clk = ~clk;

    sram_arbiter_if i2 ();
    sram_arbiter_if i4 ();

    sram_arbiter #(.ACC_CYC(2)) dut2 (.clk(clk), .clr(clr), .bus(i2.slave));
    sram_arbiter #(.ACC_CYC(4)) dut4 (.clk(clk), .clr(clr), .bus(i4.slave));

    typedef struct {
        logic [18:0] a;
        logic [15:0] d;
        int          low;
    } wlog_t;

    typedef struct {
        bit          is_w;
        logic [17:0] addr;
        logic [31:0] wdat;
        logic [18:0] a_lo;
        logic [15:0] d_lo;
        logic [18:0] a_hi;
        logic [15:0] d_hi;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        bit          is_w;
        logic [31:0] d;
    } op_t;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int viol2  = 0;
    int viol4  = 0;

    logic [15:0] mem2 [logic [18:0]];
    logic [15:0] mem4 [logic [18:0]];
    wlog_t       wq2 [$];
    wlog_t       wq4 [$];
    logic [18:0] wa2, wa4;
    logic [15:0] wd2, wd4;
    int          wlow2 = 0;
    int          wlow4 = 0;

    logic [31:0] ref_mem [logic [17:0]];
    bit          ref_last_w;
    logic [17:0] wa_q [$];
    logic [31:0] wd_q [$];
    logic [17:0] ra_q [$];

    // SRAM models: write data captured while we_n is low, logged when the pulse ends.
    always @(posedge clk) begin
        if (mon_en) begin
            if (!i2.sram_ce_n && !i2.sram_we_n) begin
                mem2[i2.sram_addr] = i2.data_o;
                wa2 = i2.sram_addr; wd2 = i2.data_o; wlow2++;
            end else if (wlow2 != 0) begin
                wq2.push_back('{wa2, wd2, wlow2}); wlow2 = 0;
            end
            if (!i4.sram_ce_n && !i4.sram_we_n) begin
                mem4[i4.sram_addr] = i4.data_o;
                wa4 = i4.sram_addr; wd4 = i4.data_o; wlow4++;
            end else if (wlow4 != 0) begin
                wq4.push_back('{wa4, wd4, wlow4}); wlow4 = 0;
            end
        end
    end

    // SRAM read port: garbage whenever the chip is not output-enabled.
    always @(negedge clk) begin
        if (!i2.sram_ce_n && !i2.sram_oe_n)
            i2.data_i = mem2.exists(i2.sram_addr) ? mem2[i2.sram_addr] : 16'h0000;
        else
            i2.data_i = 16'hA5A5;
        if (!i4.sram_ce_n && !i4.sram_oe_n)
            i4.data_i = mem4.exists(i4.sram_addr) ? mem4[i4.sram_addr] : 16'h0000;
        else
            i4.data_i = 16'hA5A5;
    end

    // Pin-level safety: we_n/oe_n never both low, pad never driven while oe_n is low.
    always @(negedge clk) begin
        if (mon_en) begin
            if ((!i2.sram_we_n && !i2.sram_oe_n) || (i2.data_oe && !i2.sram_oe_n)) viol2++;
            if ((!i4.sram_we_n && !i4.sram_oe_n) || (i4.data_oe && !i4.sram_oe_n)) viol4++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        i2.wr_req = 1'b0; i2.rd_req = 1'b0;
        i4.wr_req = 1'b0; i4.rd_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        mon_en = 1'b1;
        ref_last_w = 1'b0;
        chk("rst_strobes", {i2.sram_ce_n, i2.sram_oe_n, i2.sram_we_n, i2.sram_ub_n, i2.sram_lb_n}, 5'h1f);
        chk("rst_data_oe", i2.data_oe, 0);
        chk("rst_data_o", i2.data_o, 0);
        chk("rst_sram_addr", i2.sram_addr, 0);
        chk("rst_ack_vld", {i2.wr_ack, i2.rd_vld}, 0);
        chk("rst_rd_data", i2.rd_data, 0);
        chk("rst_busy", {i2.busy, i4.busy}, 0);
    endtask

    // One isolated transaction on the ACC_CYC=2 instance.
    task automatic run_vec(input vec_t v, input int idx);
        int t, n, base;
        bit oe_bad, done, other;
        base = wq2.size();
        @(negedge clk);
        if (v.is_w) begin
            i2.wr_addr = v.addr; i2.wr_data = v.wdat; i2.wr_req = 1'b1;
        end else begin
            i2.rd_addr = v.addr; i2.rd_req = 1'b1;
        end
        t = 0;
        do begin @(negedge clk); t++; end while (!i2.busy && t < 10);
        chk($sformatf("v%0d_grant", idx), i2.busy, 1);
        oe_bad = i2.data_oe; done = 1'b0; other = 1'b0; n = 0;
        while (!done && n < 40) begin
            @(negedge clk); n++;
            if (i2.data_oe) oe_bad = 1'b1;
            done  = v.is_w ? i2.wr_ack : i2.rd_vld;
            other = other | (v.is_w ? i2.rd_vld : i2.wr_ack);
        end
        i2.wr_req = 1'b0; i2.rd_req = 1'b0;
        // n edges after grant raise the pulse; the requester samples it on edge n+1
        chk($sformatf("v%0d_latency", idx), n + 1, 5);
        chk($sformatf("v%0d_wrong_pulse", idx), other, 0);
        if (v.is_w) begin
            chk($sformatf("v%0d_wr_count", idx), wq2.size() - base, 2);
            if (wq2.size() - base == 2) begin
                chk($sformatf("v%0d_lo", idx), {wq2[base].a, wq2[base].d, 8'(wq2[base].low)},
                    {v.a_lo, v.d_lo, 8'd1});
                chk($sformatf("v%0d_hi", idx), {wq2[base+1].a, wq2[base+1].d, 8'(wq2[base+1].low)},
                    {v.a_hi, v.d_hi, 8'd1});
            end
        end else begin
            chk($sformatf("v%0d_rd_data", idx), i2.rd_data, v.rd);
            chk($sformatf("v%0d_rd_oe", idx), oe_bad, 0);
        end
        @(negedge clk);
        chk($sformatf("v%0d_pulse_1cyc", idx), {i2.wr_ack, i2.rd_vld, i2.busy}, 0);
    endtask

    // Run nw writes and nr reads, re-raising each side right after service,
    // and compare completion order and read data with the reference model.
    task automatic serve(input int nw, input int nr, input string tag, output logic [7:0] order);
        op_t exp_q [$];
        op_t got_q [$];
        op_t o;
        int pw, pr, iw, ir, cyc;
        bit w_re, r_re, last;
        order = 8'h0;
        pw = nw; pr = nr; iw = 0; ir = 0; last = ref_last_w;
        while (pw > 0 || pr > 0) begin
            if (pw > 0 && (pr == 0 || !last)) begin
                ref_mem[wa_q[iw]] = wd_q[iw];
                o.is_w = 1'b1; o.d = wd_q[iw];
                iw++; pw--; last = 1'b1;
            end else begin
                o.is_w = 1'b0;
                o.d = ref_mem.exists(ra_q[ir]) ? ref_mem[ra_q[ir]] : 32'h0;
                ir++; pr--; last = 1'b0;
            end
            exp_q.push_back(o);
        end
        ref_last_w = last;
        iw = 0; ir = 0; w_re = 1'b0; r_re = 1'b0;
        @(negedge clk);
        if (nw > 0) begin i2.wr_addr = wa_q[0]; i2.wr_data = wd_q[0]; i2.wr_req = 1'b1; end
        if (nr > 0) begin i2.rd_addr = ra_q[0]; i2.rd_req = 1'b1; end
        cyc = 0;
        while (got_q.size() < nw + nr && cyc < 400) begin
            @(negedge clk); cyc++;
            if (w_re) begin
                w_re = 1'b0;
                if (iw < nw) begin i2.wr_addr = wa_q[iw]; i2.wr_data = wd_q[iw]; i2.wr_req = 1'b1; end
            end
            if (r_re) begin
                r_re = 1'b0;
                if (ir < nr) begin i2.rd_addr = ra_q[ir]; i2.rd_req = 1'b1; end
            end
            if (i2.wr_ack) begin
                o.is_w = 1'b1; o.d = wd_q[iw]; got_q.push_back(o);
                iw++; i2.wr_req = 1'b0; w_re = 1'b1;
            end
            if (i2.rd_vld) begin
                o.is_w = 1'b0; o.d = i2.rd_data; got_q.push_back(o);
                ir++; i2.rd_req = 1'b0; r_re = 1'b1;
            end
        end
        chk({tag, "_count"}, got_q.size(), nw + nr);
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            if (k < 8) order[k] = got_q[k].is_w;
            chk($sformatf("%s_kind%0d", tag, k), got_q[k].is_w, exp_q[k].is_w);
            if (!exp_q[k].is_w)
                chk($sformatf("%s_rdata%0d", tag, k), got_q[k].d, exp_q[k].d);
        end
    endtask

    initial begin
        vec_t        vt [7];
        logic [7:0]  ord;
        int          t, n, base, nw, nr;
        bit          vld_seen;

        vt[0] = '{1'b1, 18'h00003, 32'h2021_0815, 19'h00006, 16'h0815, 19'h00007, 16'h2021, 32'h0};
        vt[1] = '{1'b0, 18'h00003, 32'h0,         19'h0,     16'h0,    19'h0,     16'h0,    32'h2021_0815};
        vt[2] = '{1'b1, 18'h3FFFF, 32'hDEAD_BEEF, 19'h7FFFE, 16'hBEEF, 19'h7FFFF, 16'hDEAD, 32'h0};
        vt[3] = '{1'b0, 18'h3FFFF, 32'h0,         19'h0,     16'h0,    19'h0,     16'h0,    32'hDEAD_BEEF};
        vt[4] = '{1'b0, 18'h00010, 32'h0,         19'h0,     16'h0,    19'h0,     16'h0,    32'h0};
        vt[5] = '{1'b1, 18'h00000, 32'hFFFF_0000, 19'h00000, 16'h0000, 19'h00001, 16'hFFFF, 32'h0};
        vt[6] = '{1'b0, 18'h00000, 32'h0,         19'h0,     16'h0,    19'h0,     16'h0,    32'hFFFF_0000};

        clr = 1'b1;
        i2.wr_req = 1'b0; i2.rd_req = 1'b0; i2.wr_addr = '0; i2.wr_data = '0; i2.rd_addr = '0;
        i4.wr_req = 1'b0; i4.rd_req = 1'b0; i4.wr_addr = '0; i4.wr_data = '0; i4.rd_addr = '0;
        do_reset();

        for (int i = 0; i < 7; i++) run_vec(vt[i], i);

        // Abort a read in its final phase cycle.
        do_reset();
        @(negedge clk);
        i2.rd_addr = 18'h00003; i2.rd_req = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!i2.busy && t < 10);
        chk("clr_grant", i2.busy, 1);
        repeat (3) @(negedge clk);
        chk("clr_in_rd_hi", {i2.sram_addr, i2.sram_oe_n}, {19'h00007, 1'b0});
        clr = 1'b1; i2.rd_req = 1'b0;
        @(negedge clk);
        chk("clr_strobes", {i2.sram_ce_n, i2.sram_oe_n, i2.sram_we_n, i2.sram_ub_n, i2.sram_lb_n}, 5'h1f);
        chk("clr_busy", i2.busy, 0);
        clr = 1'b0;
        vld_seen = i2.rd_vld;
        repeat (8) begin @(negedge clk); vld_seen |= i2.rd_vld; end
        chk("clr_no_vld", vld_seen, 0);
        chk("clr_rd_data", i2.rd_data, 0);

        // Both sides requesting from reset: W, R, W, R.
        do_reset();
        wa_q = '{18'h00200, 18'h00201}; wd_q = '{32'h1111_2222, 32'h3333_4444};
        ra_q = '{18'h00200, 18'h00201};
        serve(2, 2, "alt", ord);
        chk("alt_order", ord[3:0], 4'b0101);

        // Randomized mixes against the reference model.
        for (int it = 0; it < 12; it++) begin
            nw = $urandom_range(0, 3);
            nr = $urandom_range(0, 3);
            if (nw + nr == 0) nw = 1;
            wa_q.delete(); wd_q.delete(); ra_q.delete();
            for (int j = 0; j < nw; j++) begin
                wa_q.push_back(18'h00100 + 18'($urandom_range(0, 3)));
                wd_q.push_back($urandom());
            end
            for (int j = 0; j < nr; j++) ra_q.push_back(18'h00100 + 18'($urandom_range(0, 3)));
            serve(nw, nr, $sformatf("rnd%0d", it), ord);
        end

        // ACC_CYC=4: inputs changed during WR_LO must not reach the SRAM.
        base = wq4.size();
        @(negedge clk);
        i4.wr_addr = 18'h000AB; i4.wr_data = 32'hCAFE_F00D; i4.wr_req = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!i4.busy && t < 10);
        chk("c4_grant", i4.busy, 1);
        @(negedge clk);
        i4.wr_addr = 18'h001FF; i4.wr_data = 32'h1234_5678;
        n = 1;
        while (!i4.wr_ack && n < 40) begin @(negedge clk); n++; end
        i4.wr_req = 1'b0;
        chk("c4_latency", n + 1, 9);
        chk("c4_wr_count", wq4.size() - base, 2);
        if (wq4.size() - base == 2) begin
            chk("c4_lo", {wq4[base].a, wq4[base].d, 8'(wq4[base].low)}, {19'h00156, 16'hF00D, 8'd3});
            chk("c4_hi", {wq4[base+1].a, wq4[base+1].d, 8'(wq4[base+1].low)}, {19'h00157, 16'hCAFE, 8'd3});
        end
        @(negedge clk);
        chk("c4_pulse_1cyc", {i4.wr_ack, i4.busy}, 0);

        chk("strobe_excl_c2", viol2, 0);
        chk("strobe_excl_c4", viol4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
